led_breather: RTL and testbench
===============================

LED_BREATHER -- requirements
Module: led_breather

Interface
REQ-001 SHALL have parameter STEP_BIT, default 11: index of the currentCount bit whose rising edge is one duty-update tick.
REQ-002 SHALL have parameter STEP, default 8: duty increment/decrement per tick.
REQ-003 SHALL have parameter HOLD_TICKS, default 4: ticks spent in each hold state; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port currentCount, input, 16: free-running count from the upstream counter.
REQ-007 SHALL have port enable, input, 1: high runs the breathing sequence, low forces IDLE.
REQ-008 SHALL have port pwm_out, output, 1: registered PWM LED drive.
REQ-009 SHALL have port duty, output, 8: current duty value, registered.
REQ-010 SHALL have port state, output, 3: current FSM state encoding.
REQ-011 SHALL have port cycle_done, output, 1: one-clk pulse at the end of each full breath.

Function
REQ-012 SHALL form tick = currentCount[STEP_BIT] & ~prev_bit; prev_bit is a register updated every clk in every state.
REQ-013 SHALL implement states IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
REQ-014 IDLE: duty=0, pwm_out=0; enable high -> RAMP_UP on the next clk without waiting for a tick.
REQ-015 RAMP_UP: on tick, duty = min(duty+STEP, 255), computed 9-bit and saturated; the tick that sets duty to 255 moves to HOLD_HIGH.
REQ-016 RAMP_DOWN: on tick, duty = max(duty-STEP, 0), with underflow detected, not wrapped; the tick that sets duty to 0 moves to HOLD_LOW.
REQ-017 HOLD_HIGH/HOLD_LOW: hold_cnt increments per tick; on the tick with hold_cnt==HOLD_TICKS-1, hold_cnt clears and state leaves: HOLD_HIGH->RAMP_DOWN, HOLD_LOW->RAMP_UP.
REQ-018 HOLD_LOW->RAMP_UP transition SHALL assert cycle_done for exactly that one clk; cycle_done is 0 otherwise.
REQ-019 hold_cnt SHALL be cleared on every entry to a hold state.
REQ-020 Without a tick, duty, state and hold_cnt SHALL hold.
REQ-021 pwm_out(t+1) SHALL equal (currentCount[7:0](t) < duty(t)) outside IDLE: duty 0 -> always low; duty 255 -> high 255 of 256 count values.
REQ-022 enable low in any state SHALL, on the next clk, force IDLE, duty=0, pwm_out=0, hold_cnt=0; this takes priority over a simultaneous tick.
REQ-023 Ticks are ignored in IDLE; duty updates only on ticks, so latency from input edge to duty change is one clk.
REQ-024 currentCount wrap (0xFFFF->0x0000) SHALL NOT create a tick, since the bit falls.

Reset
REQ-025 rst high SHALL asynchronously set state=IDLE, duty=0, pwm_out=0, cycle_done=0, hold_cnt=0, prev_bit=0.
REQ-026 Reset asserted mid-ramp or mid-hold SHALL abandon the breath; after release with enable high, the sequence restarts from RAMP_UP, duty 0.

Structure
REQ-027 Package breather_pkg SHALL hold the state enumeration and the duty width constant (8).
REQ-028 Rising-edge detection SHALL be one sub-module, edge_tick (clk, rst, level in, pulse out), instantiated once.
REQ-029 Expected size is 120-400 RTL lines; no other hierarchy.

Verification
REQ-030 Reset -> all outputs 0, state=0; enable=1 -> state=1 after 1 clk, duty=0.
REQ-031 STEP=8, enable=1, 32 ticks -> duty 8,16,...,248,255; state=2 on the 32nd tick.
REQ-032 HOLD_TICKS=4 -> 4 ticks in HOLD_HIGH, 32 ticks down to duty 0, 4 ticks in HOLD_LOW, then cycle_done=1 for one clk with state=1.
REQ-033 duty=128, currentCount[7:0] swept 0..255 -> pwm_out high for exactly 128 counts, delayed 1 clk; duty=0 -> never high.
REQ-034 enable dropped in the same clk as a tick during RAMP_DOWN -> next clk state=0, duty=0, pwm_out=0.
REQ-035 rst pulse while duty=200 in RAMP_UP -> duty=0 immediately without a clk; after release, restart from duty 0.

Source files
------------

// File: rtl/breather_pkg.sv
// Shared types and saturating duty arithmetic for the LED breathing controller.
package breather_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  // Returns {reached_max, new_duty}; the sum is formed one bit wider so the carry saturates.
  function automatic logic [DUTY_W:0] sat_inc(input logic [DUTY_W-1:0] d,
                                              input logic [DUTY_W-1:0] s);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + {1'b0, s};
    if (sum >= {1'b0, DUTY_MAX}) begin
      return {1'b1, DUTY_MAX};
    end
    return {1'b0, sum[DUTY_W-1:0]};
  endfunction

  // Returns {reached_zero, new_duty}; a borrow out of the MSB clamps to zero.
  function automatic logic [DUTY_W:0] sat_dec(input logic [DUTY_W-1:0] d,
                                              input logic [DUTY_W-1:0] s);
    logic [DUTY_W:0] diff;
    diff = {1'b0, d} - {1'b0, s};
    if (diff[DUTY_W] || (diff[DUTY_W-1:0] == '0)) begin
      return {1'b1, {DUTY_W{1'b0}}};
    end
    return {1'b0, diff[DUTY_W-1:0]};
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector: one-clk pulse when level goes 0 -> 1.
module edge_tick (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_bit <= 1'b0;
    end else begin
      prev_bit <= level;
    end
  end

  assign pulse = level & ~prev_bit;

endmodule

// File: rtl/led_breather.sv
// LED breathing controller: duty ramps up, holds, ramps down, holds, repeating while enabled.
module led_breather
  import breather_pkg::*;
#(
  parameter int STEP_BIT   = 11,
  parameter int STEP       = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       currentCount,
  input  logic              enable,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic [2:0]        state,
  output logic              cycle_done
);

  localparam logic [DUTY_W-1:0] STEP_V    = DUTY_W'(STEP);
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_TICKS - 1);

  state_t          st;
  logic [7:0]      hold_cnt;
  logic            tick;
  logic [DUTY_W:0] up_next;
  logic [DUTY_W:0] down_next;

  // Only the tick bit and the low byte feed the logic; the rest is folded away.
  logic unused_count;
  assign unused_count = ^currentCount;

  edge_tick u_edge_tick (
    .clk   (clk),
    .rst   (rst),
    .level (currentCount[STEP_BIT]),
    .pulse (tick)
  );

  assign up_next   = sat_inc(duty, STEP_V);
  assign down_next = sat_dec(duty, STEP_V);
  assign state     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      duty       <= '0;
      pwm_out    <= 1'b0;
      cycle_done <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      cycle_done <= 1'b0;
      if (!enable) begin
        // Disable wins over any tick arriving in the same cycle.
        st       <= IDLE;
        duty     <= '0;
        pwm_out  <= 1'b0;
        hold_cnt <= '0;
      end else begin
        pwm_out <= (st != IDLE) && (currentCount[DUTY_W-1:0] < duty);
        case (st)
          IDLE: begin
            duty     <= '0;
            hold_cnt <= '0;
            st       <= RAMP_UP;
          end
          RAMP_UP: begin
            if (tick) begin
              duty <= up_next[DUTY_W-1:0];
              if (up_next[DUTY_W]) begin
                st       <= HOLD_HIGH;
                hold_cnt <= '0;
              end
            end
          end
          HOLD_HIGH: begin
            if (tick) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                st       <= RAMP_DOWN;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
          end
          RAMP_DOWN: begin
            if (tick) begin
              duty <= down_next[DUTY_W-1:0];
              if (down_next[DUTY_W]) begin
                st       <= HOLD_LOW;
                hold_cnt <= '0;
              end
            end
          end
          HOLD_LOW: begin
            if (tick) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt   <= '0;
                st         <= RAMP_UP;
                cycle_done <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
          end
          default: begin
            st       <= IDLE;
            duty     <= '0;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather with default parameters (STEP_BIT=11, STEP=8, HOLD_TICKS=4).
module tb_led_breather;

  logic        clk;
  logic        rst;
  logic [15:0] cc;
  logic        enable;
  logic        pwm_out;
  logic [7:0]  duty;
  logic [2:0]  state;
  logic        cycle_done;

  int n_checks;
  int n_pass;
  int hi_cnt;
  int exp_duty;

  led_breather dut (
    .clk          (clk),
    .rst          (rst),
    .currentCount (cc),
    .enable       (enable),
    .pwm_out      (pwm_out),
    .duty         (duty),
    .state        (state),
    .cycle_done   (cycle_done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    cc[11] = 1'b1;
    step();
    cc[11] = 1'b0;
    step();
  endtask

  task automatic sweep_low_byte(output int highs);
    highs = 0;
    for (int v = 0; v < 256; v++) begin
      cc = {8'h00, 8'(v)};
      step();
      if (pwm_out) highs++;
      if (v == 127) check("pwm_at_127", int'(pwm_out), (duty == 8'd128) ? 1 : 0);
      if (v == 128) check("pwm_at_128", int'(pwm_out), 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    cc       = 16'h0000;
    #12;
    check("rst_state", int'(state), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_cdone", int'(cycle_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("idle_disabled", int'(state), 0);

    enable = 1'b1;
    step();
    check("start_state", int'(state), 1);
    check("start_duty", int'(duty), 0);

    // ramp up: 8,16,...,248 then 255 on tick 32
    for (int k = 1; k <= 32; k++) begin
      do_tick();
      exp_duty = (k * 8 > 255) ? 255 : k * 8;
      check("up_duty", int'(duty), exp_duty);
      check("up_state", int'(state), (k == 32) ? 2 : 1);
    end

    for (int k = 1; k <= 4; k++) begin
      do_tick();
      check("hold_hi_state", int'(state), (k == 4) ? 3 : 2);
      check("hold_hi_duty", int'(duty), 255);
    end

    // first down tick by hand: one-clk latency, and a held-high bit is not a second tick
    cc[11] = 1'b1;
    check("down_pre_edge", int'(duty), 255);
    step();
    check("down_latency", int'(duty), 247);
    step();
    check("held_level", int'(duty), 247);
    cc[11] = 1'b0;
    step();
    for (int k = 2; k <= 32; k++) begin
      do_tick();
      exp_duty = (255 - 8 * k < 0) ? 0 : 255 - 8 * k;
      check("down_duty", int'(duty), exp_duty);
      check("down_state", int'(state), (k == 32) ? 4 : 3);
    end

    for (int k = 1; k <= 3; k++) begin
      do_tick();
      check("hold_lo_state", int'(state), 4);
      check("hold_lo_cdone", int'(cycle_done), 0);
    end
    cc[11] = 1'b1;
    step();
    check("breath_end_state", int'(state), 1);
    check("breath_end_cdone", int'(cycle_done), 1);
    check("breath_end_duty", int'(duty), 0);
    cc[11] = 1'b0;
    step();
    check("cdone_one_clk", int'(cycle_done), 0);

    // PWM at duty 128
    enable = 1'b0;
    step();
    check("dis_state", int'(state), 0);
    enable = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) do_tick();
    check("duty_128", int'(duty), 128);
    cc = 16'h00C8;
    step();
    check("pwm_c8_low", int'(pwm_out), 0);
    cc = 16'h0005;
    check("pwm_registered", int'(pwm_out), 0);
    step();
    check("pwm_delay", int'(pwm_out), 1);
    sweep_low_byte(hi_cnt);
    check("pwm_high_128", hi_cnt, 128);

    // PWM at duty 0
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    check("duty_zero", int'(duty), 0);
    sweep_low_byte(hi_cnt);
    check("pwm_high_0", hi_cnt, 0);

    // counter wrap: 0xFFFF raises bit 11 (a tick), wrapping to 0 must not tick
    cc = 16'hFFFF;
    step();
    check("ffff_tick", int'(duty), 8);
    cc = 16'h0000;
    step();
    step();
    check("wrap_no_tick", int'(duty), 8);

    // enable drop coincident with a tick in RAMP_DOWN
    for (int k = 1; k <= 31; k++) do_tick();
    check("pre_hold_duty", int'(duty), 255);
    for (int k = 1; k <= 4; k++) do_tick();
    check("pre_drop_state", int'(state), 3);
    do_tick();
    do_tick();
    check("pre_drop_duty", int'(duty), 239);
    cc[11] = 1'b1;
    enable = 1'b0;
    step();
    check("drop_state", int'(state), 0);
    check("drop_duty", int'(duty), 0);
    check("drop_pwm", int'(pwm_out), 0);
    cc[11] = 1'b0;
    step();

    // asynchronous reset mid-ramp
    enable = 1'b1;
    step();
    for (int k = 1; k <= 25; k++) do_tick();
    check("pre_rst_duty", int'(duty), 200);
    rst = 1'b1;
    #1;
    check("async_rst_duty", int'(duty), 0);
    check("async_rst_state", int'(state), 0);
    #1;
    rst = 1'b0;
    step();
    check("restart_state", int'(state), 1);
    check("restart_duty", int'(duty), 0);
    do_tick();
    check("restart_first_tick", int'(duty), 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
